// File: rtl/mux_pkg.sv
// Shared types, constants and elaboration-time helpers for the pipelined mux tree.
package mux_pkg;

    localparam int SB_SEL_W       = 32;
    localparam int MUX_RESET_DATA = 0;

    // Sideband carried alongside each tree level's data.
    typedef struct packed {
        logic                valid;
        logic [SB_SEL_W-1:0] sel;
        logic                err;
    } stage_sb_t;

    function automatic int mux_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int mux_clog_radix(input int n, input int radix);
        int     l;
        longint p;
        l = 0;
        p = 1;
        while (p < longint'(n)) begin
            p = p * longint'(radix);
            l++;
        end
        return l;
    endfunction

    function automatic int mux_pow(input int b, input int e);
        int r;
        r = 1;
        for (int i = 0; i < e; i++) r = r * b;
        return r;
    endfunction

endpackage

// File: rtl/mux_tree_stage.sv
// One tree level: GROUPS independent RADIX:1 selects, registered with an adv enable.
module mux_tree_stage
    import mux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int RADIX  = 8,
    parameter int GROUPS = 1,
    parameter int LEVEL  = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          adv,
    input  logic [GROUPS*RADIX*DATA_W-1:0] in_data,
    input  stage_sb_t                     in_sb,
    output logic [GROUPS*DATA_W-1:0]       out_data,
    output stage_sb_t                     out_sb
);

    localparam int DIG_W = mux_clog2(RADIX);

    logic [DIG_W-1:0]         digit;
    logic [GROUPS*DATA_W-1:0] sel_data;

    assign digit = in_sb.sel[LEVEL*DIG_W +: DIG_W];

    // Bubbles and out-of-range requests propagate zero data.
    always_comb begin
        // NOTE: default assigned first so no path leaves sel_data unassigned (no latch).
        sel_data = '0;
        if (in_sb.valid && !in_sb.err) begin
            for (int g = 0; g < GROUPS; g++)
                sel_data[g*DATA_W +: DATA_W] = in_data[(g*RADIX + int'(digit))*DATA_W +: DATA_W];
        end
    end

    // NOTE: sequential state uses non-blocking assignments; data is reset too so outputs are defined.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= (GROUPS*DATA_W)'(MUX_RESET_DATA);
            out_sb   <= '0;
        end else if (adv) begin
            out_data <= sel_data;
            out_sb   <= in_sb;
        end
    end

endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined N:1 radix-R selector tree with valid/ready flow control.
// Optional MUX_SCAN_EN adds a scan_en port and an auto-incrementing select counter.
module mux_tree_pipe
    import mux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NUM_IN = 64,
    parameter int RADIX  = 8,
    parameter int SEL_W  = mux_clog2(NUM_IN),
    parameter int LEVELS = mux_clog_radix(NUM_IN, RADIX)
) (
    input  logic                     clk,
    input  logic                     rst,
`ifdef MUX_SCAN_EN
    input  logic                     scan_en,
`endif
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_sel,
    output logic                     out_err,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int PAD_IN = mux_pow(RADIX, LEVELS);
    localparam int PAD_W  = PAD_IN * DATA_W;

    logic             adv;
    logic [SEL_W-1:0] sel_eff;
    logic             sel_err;

    logic [PAD_W-1:0] lvl_data [0:LEVELS];
    stage_sb_t        lvl_sb   [0:LEVELS];

    // Whole pipe moves in lockstep: no bubble collapsing.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

`ifdef MUX_SCAN_EN
    logic [SEL_W-1:0] scan_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            scan_cnt <= '0;
        else if (scan_en && in_valid && adv)
            scan_cnt <= (scan_cnt == SEL_W'(NUM_IN - 1)) ? '0 : scan_cnt + 1'b1;
    end

    assign sel_eff = scan_en ? scan_cnt : in_sel;
`else
    assign sel_eff = in_sel;
`endif

    assign sel_err = {1'b0, sel_eff} >= (SEL_W+1)'(NUM_IN);

    // Stage 0 only loads when adv is high, so in_valid there equals an accept.
    assign lvl_sb[0]   = '{valid: in_valid, sel: SB_SEL_W'(sel_eff), err: sel_err};
    assign lvl_data[0] = PAD_W'(in_data);

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int GROUPS = mux_pow(RADIX, LEVELS - 1 - l);
        localparam int IN_W   = GROUPS * RADIX * DATA_W;
        localparam int OUT_W  = GROUPS * DATA_W;

        mux_tree_stage #(
            .DATA_W (DATA_W),
            .RADIX  (RADIX),
            .GROUPS (GROUPS),
            .LEVEL  (l)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .adv      (adv),
            .in_data  (lvl_data[l][IN_W-1:0]),
            .in_sb    (lvl_sb[l]),
            .out_data (lvl_data[l+1][OUT_W-1:0]),
            .out_sb   (lvl_sb[l+1])
        );

        assign lvl_data[l+1][PAD_W-1:OUT_W] = '0;
    end

    assign out_data  = lvl_data[LEVELS][DATA_W-1:0];
    assign out_sel   = lvl_sb[LEVELS].sel[SEL_W-1:0];
    assign out_err   = lvl_sb[LEVELS].err;
    assign out_valid = lvl_sb[LEVELS].valid;

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Self-checking bench for mux_tree_pipe: 64:1 default instance plus a 40:1 instance for range errors.
module tb_mux_tree_pipe;

    localparam int DATA_W   = 8;
    localparam int NUM_IN   = 64;
    localparam int RADIX    = 8;
    localparam int SEL_W    = 6;
    localparam int LEVELS   = 2;
    localparam int B_NUM_IN = 40;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_IN*DATA_W-1:0] in_data;
    logic [SEL_W-1:0]         in_sel;
    logic                     in_valid, in_ready;
    logic [DATA_W-1:0]        out_data;
    logic [SEL_W-1:0]         out_sel;
    logic                     out_err, out_valid, out_ready;

    logic [B_NUM_IN*DATA_W-1:0] b_in_data;
    logic [SEL_W-1:0]           b_in_sel;
    logic                       b_in_valid, b_in_ready;
    logic [DATA_W-1:0]          b_out_data;
    logic [SEL_W-1:0]           b_out_sel;
    logic                       b_out_err, b_out_valid, b_out_ready;

`ifdef MUX_SCAN_EN
    logic scan_en;
    logic b_scan_en;
`endif

    always #5 clk = ~clk;

    mux_tree_pipe #(.DATA_W(DATA_W), .NUM_IN(NUM_IN), .RADIX(RADIX)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef MUX_SCAN_EN
        .scan_en   (scan_en),
`endif
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    mux_tree_pipe #(.DATA_W(DATA_W), .NUM_IN(B_NUM_IN), .RADIX(RADIX)) dut40 (
        .clk       (clk),
        .rst       (rst),
`ifdef MUX_SCAN_EN
        .scan_en   (b_scan_en),
`endif
        .in_data   (b_in_data),
        .in_sel    (b_in_sel),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .out_data  (b_out_data),
        .out_sel   (b_out_sel),
        .out_err   (b_out_err),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready)
    );

    // Reference model: a FIFO of expected results, each due once LEVELS advancing edges have elapsed.
    typedef struct {
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] data;
        logic              err;
        int                due;
    } item_t;

    item_t exp_q[$];
    int    adv_count;
    int    scan_cnt;
    int    n_tests;
    int    n_fail;

    function automatic logic exp_valid();
        return (exp_q.size() > 0) && (exp_q[0].due == adv_count);
    endfunction

    function automatic item_t exp_head();
        item_t e;
        e = '{default: 0};
        if (exp_valid()) e = exp_q[0];
        return e;
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        adv_count = 0;
        scan_cnt  = 0;
    endfunction

    // Advance the model by one clock using the currently driven inputs, then clock the DUT.
    task automatic tick();
        logic  v, adv;
        item_t it;
        int    s;
        v   = exp_valid();
        adv = !v || out_ready;
        if (v && adv) void'(exp_q.pop_front());
        if (in_valid && adv) begin
            s = int'(in_sel);
`ifdef MUX_SCAN_EN
            if (scan_en) begin
                s        = scan_cnt;
                scan_cnt = (scan_cnt + 1) % NUM_IN;
            end
`endif
            it.sel  = SEL_W'(s);
            it.err  = (s >= NUM_IN);
            it.data = it.err ? '0 : in_data[s*DATA_W +: DATA_W];
            it.due  = adv_count + LEVELS;
            exp_q.push_back(it);
        end
        if (adv) adv_count++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        n_tests++;
        if ({out_valid, out_data, out_sel, out_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b d=%h s=%0d e=%b want all 0",
                     out_valid, out_data, out_sel, out_err);
        end
        n_tests++;
        if ({b_out_valid, b_out_data, b_out_sel, b_out_err, b_in_ready} !== {{(2+DATA_W+SEL_W){1'b0}}, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_outputs40: got v=%b d=%h s=%0d e=%b rdy=%b want 0/0/0/0/1",
                     b_out_valid, b_out_data, b_out_sel, b_out_err, b_in_ready);
        end
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset: got rdy=%b v=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_single();
        for (int k = 0; k < NUM_IN; k++) in_data[k*DATA_W +: DATA_W] = DATA_W'(k);
        in_sel    = 6'd37;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        in_data  = {16{$urandom()}};
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_early: got v=%b want 0 one cycle after accept", out_valid);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 8'd37 || out_sel !== 6'd37 || out_err !== 1'b0) begin
            n_fail++;
            $display("FAIL single_result: got v=%b d=%0d s=%0d e=%b want 1/37/37/0",
                     out_valid, out_data, out_sel, out_err);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_dup: got v=%b want 0 after handshake", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int          sels[4] = '{0, 1, 63, 8};
        int          got_sel[$];
        int          got_cyc[$];
        logic        ev;
        item_t       e;
        logic        ok;
        in_data   = {16{$urandom()}};
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_valid = (c < 4);
            in_sel   = (c < 4) ? SEL_W'(sels[c]) : SEL_W'($urandom());
            tick();
            ev = exp_valid();
            e  = exp_head();
            n_tests++;
            if (out_valid !== ev || in_ready !== (!ev || out_ready) ||
                (ev && (out_data !== e.data || out_sel !== e.sel || out_err !== e.err))) begin
                n_fail++;
                $display("FAIL b2b c%0d: got v=%b rdy=%b d=%h s=%0d e=%b want v=%b d=%h s=%0d e=%b",
                         c, out_valid, in_ready, out_data, out_sel, out_err, ev, e.data, e.sel, e.err);
            end
            if (out_valid === 1'b1) begin
                got_sel.push_back(int'(out_sel));
                got_cyc.push_back(c);
            end
        end
        ok = (got_sel.size() == 4);
        if (ok) begin
            for (int i = 0; i < 4; i++) if (got_sel[i] != sels[i]) ok = 1'b0;
            if (got_cyc[3] - got_cyc[0] != 3) ok = 1'b0;
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL b2b_order: got %0d results %p at cycles %p want sels 0,1,63,8 on consecutive cycles",
                     got_sel.size(), got_sel, got_cyc);
        end
    endtask

    task automatic test_stall();
        logic              ev;
        item_t             e;
        int                n_out;
        logic [DATA_W-1:0] held;
        n_out = 0;
        held  = '0;
        for (int c = 0; c < 12; c++) begin
            in_valid  = (c < 8);
            in_sel    = SEL_W'($urandom());
            in_data   = {16{$urandom()}};
            out_ready = !(c >= 3 && c < 8);
            #1;
            if (c == 3) held = out_data;
            if (c >= 3 && c < 8) begin
                n_tests++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== held) begin
                    n_fail++;
                    $display("FAIL stall_hold c%0d: got rdy=%b v=%b d=%h want 0/1/%h",
                             c, in_ready, out_valid, out_data, held);
                end
            end
            if (out_valid === 1'b1 && out_ready) n_out++;
            tick();
            ev = exp_valid();
            e  = exp_head();
            n_tests++;
            if (out_valid !== ev || in_ready !== (!ev || out_ready) ||
                (ev && (out_data !== e.data || out_sel !== e.sel || out_err !== e.err))) begin
                n_fail++;
                $display("FAIL stall c%0d: got v=%b rdy=%b d=%h s=%0d e=%b want v=%b d=%h s=%0d e=%b",
                         c, out_valid, in_ready, out_data, out_sel, out_err, ev, e.data, e.sel, e.err);
            end
        end
        n_tests++;
        if (n_out != 3 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL stall_count: got %0d results, %0d pending want 3 results, 0 pending",
                     n_out, exp_q.size());
        end
    endtask

    task automatic test_random();
        logic  ev;
        item_t e;
        for (int c = 0; c < 1506; c++) begin
            in_valid  = (c < 1500) && ($urandom_range(0, 9) < 7);
            out_ready = (c >= 1500) || ($urandom_range(0, 9) < 7);
            in_sel    = SEL_W'($urandom());
            in_data   = {16{$urandom()}};
            tick();
            ev = exp_valid();
            e  = exp_head();
            n_tests++;
            if (out_valid !== ev || in_ready !== (!ev || out_ready) ||
                (ev && (out_data !== e.data || out_sel !== e.sel || out_err !== e.err))) begin
                n_fail++;
                $display("FAIL random c%0d: got v=%b rdy=%b d=%h s=%0d e=%b want v=%b d=%h s=%0d e=%b",
                         c, out_valid, in_ready, out_data, out_sel, out_err, ev, e.data, e.sel, e.err);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_err40();
        logic [DATA_W-1:0] chan39;
        in_valid    = 1'b0;
        b_in_data   = {10{$urandom()}};
        chan39      = b_in_data[39*DATA_W +: DATA_W];
        b_out_ready = 1'b1;
        b_in_sel    = 6'd45;
        b_in_valid  = 1'b1;
        @(posedge clk);
        #1;
        b_in_sel = 6'd39;
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        b_in_data  = {10{$urandom()}};
        n_tests++;
        if (b_out_valid !== 1'b1 || b_out_data !== 8'd0 || b_out_err !== 1'b1 || b_out_sel !== 6'd45) begin
            n_fail++;
            $display("FAIL err40_range: got v=%b d=%h s=%0d e=%b want 1/00/45/1",
                     b_out_valid, b_out_data, b_out_sel, b_out_err);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (b_out_valid !== 1'b1 || b_out_data !== chan39 || b_out_err !== 1'b0 || b_out_sel !== 6'd39) begin
            n_fail++;
            $display("FAIL err40_last: got v=%b d=%h s=%0d e=%b want 1/%h/39/0",
                     b_out_valid, b_out_data, b_out_sel, b_out_err, chan39);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (b_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL err40_drain: got v=%b want 0", b_out_valid);
        end
    endtask

    task automatic test_reset_inflight();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_sel    = SEL_W'($urandom());
        tick();
        in_sel = SEL_W'($urandom());
        tick();
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL inflight_setup: got v=%b want 1 before reset", out_valid);
        end
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL inflight_reset: got v=%b rdy=%b want 0/1", out_valid, in_ready);
        end
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            n_tests++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL inflight_stale c%0d: got v=%b s=%0d want 0", c, out_valid, out_sel);
            end
        end
    endtask

`ifdef MUX_SCAN_EN
    task automatic test_scan();
        logic  ev;
        item_t e;
        int    got_sel[$];
        logic  any_err;
        logic  ok;
        scan_en   = 1'b1;
        out_ready = 1'b1;
        any_err   = 1'b0;
        for (int c = 0; c < 72; c++) begin
            in_valid = (c < 66);
            in_sel   = SEL_W'($urandom());
            in_data  = {16{$urandom()}};
            #1;
            if (out_valid === 1'b1 && out_ready) begin
                got_sel.push_back(int'(out_sel));
                if (out_err !== 1'b0) any_err = 1'b1;
            end
            tick();
            ev = exp_valid();
            e  = exp_head();
            n_tests++;
            if (out_valid !== ev || in_ready !== (!ev || out_ready) ||
                (ev && (out_data !== e.data || out_sel !== e.sel || out_err !== e.err))) begin
                n_fail++;
                $display("FAIL scan c%0d: got v=%b rdy=%b d=%h s=%0d e=%b want v=%b d=%h s=%0d e=%b",
                         c, out_valid, in_ready, out_data, out_sel, out_err, ev, e.data, e.sel, e.err);
            end
        end
        ok = (got_sel.size() == 66) && !any_err;
        if (ok) for (int i = 0; i < 66; i++) if (got_sel[i] != i % NUM_IN) ok = 1'b0;
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL scan_seq: got %0d results err_seen=%b want 66 results 0..63,0,1 with no err",
                     got_sel.size(), any_err);
        end
        scan_en = 1'b0;
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        in_data     = '0;
        in_sel      = '0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        b_in_data   = '0;
        b_in_sel    = '0;
        b_in_valid  = 1'b0;
        b_out_ready = 1'b0;
`ifdef MUX_SCAN_EN
        scan_en   = 1'b0;
        b_scan_en = 1'b0;
`endif
        n_tests = 0;
        n_fail  = 0;
        model_reset();

        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_random();
        test_err40();
        test_reset_inflight();
`ifdef MUX_SCAN_EN
        test_scan();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
